// File: rtl/multdiv_issue.sv
// Issue sequencer between execute and the shared multiply/divide unit: latches one op,
// pulses the unit, stalls until a result (or timeout) and presents a single writeback beat.
module multdiv_issue #(
  parameter int unsigned TIMEOUT   = 40,
  parameter int unsigned MULT_CODE = 4,
  parameter int unsigned DIV_CODE  = 5,
  parameter int unsigned EXC_REG   = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_mult,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  output logic        stall,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] data_result,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     res_q, res_d;
  logic            exc_q, exc_d;
  logic [31:0]     md_a_q, md_b_q;
  logic [4:0]      rd_q;
  logic            is_mult_q;
  logic            ctrl_mult_q, ctrl_div_q;
  logic            accept;

  // Exactly one type bit must be set; malformed ops are ignored without stalling.
  assign accept = (state_q == StIdle) & op_valid & (op_is_mult ^ op_is_div);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StStart;
      end
      StStart: begin
        // RDY may still be high from the previous op here, so it is not looked at.
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        if (data_resultRDY) begin
          res_d   = data_result;
          exc_d   = data_exception;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      res_q       <= '0;
      exc_q       <= 1'b0;
      md_a_q      <= '0;
      md_b_q      <= '0;
      rd_q        <= '0;
      is_mult_q   <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      exc_q       <= exc_d;
      ctrl_mult_q <= accept & op_is_mult;
      ctrl_div_q  <= accept & op_is_div;
      if (accept) begin
        md_a_q    <= op_a;
        md_b_q    <= op_b;
        rd_q      <= op_rd;
        is_mult_q <= op_is_mult;
      end
    end
  end

  always_comb begin
    stall        = accept | (state_q == StStart) | (state_q == StBusy);
    ctrl_MULT    = ctrl_mult_q;
    ctrl_DIV     = ctrl_div_q;
    md_a         = md_a_q;
    md_b         = md_b_q;
    wb_valid     = (state_q == StDone);
    wb_rd        = '0;
    wb_data      = '0;
    wb_exception = 1'b0;
    if (wb_valid) begin
      if (exc_q) begin
        wb_rd        = 5'(EXC_REG);
        wb_data      = is_mult_q ? 32'(MULT_CODE) : 32'(DIV_CODE);
        wb_exception = 1'b1;
      end else begin
        wb_rd   = rd_q;
        wb_data = res_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: fixed ops with hand-computed writeback values and timing.
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid, op_is_mult, op_is_div;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        stall, ctrl_MULT, ctrl_DIV;
  logic [31:0] md_a, md_b;
  logic [31:0] data_result;
  logic        data_resultRDY, data_exception;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  int errors  = 0;
  int checks  = 0;
  int wb_seen = 0;

  multdiv_issue dut (
    .clock          (clock),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_is_mult     (op_is_mult),
    .op_is_div      (op_is_div),
    .op_a           (op_a),
    .op_b           (op_b),
    .op_rd          (op_rd),
    .stall          (stall),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .md_a           (md_a),
    .md_b           (md_b),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (wb_valid === 1'b1) wb_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Drives one op from accept through the writeback beat; n is the number of BUSY cycles.
  task automatic run_op(input string tag, input logic mult, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int n,
                        input logic give_rdy, input logic [31:0] res, input logic exc,
                        input logic stale, input logic [4:0] exp_rd,
                        input logic [31:0] exp_data, input logic exp_exc);
    int wb0;
    int bad;
    wb0 = wb_seen;
    bad = 0;
    op_valid = 1'b1; op_is_mult = mult; op_is_div = !mult;
    op_a = a; op_b = b; op_rd = rd;
    data_resultRDY = 1'b0;
    #3;
    chk({tag, ".stall_accept"}, 32'(stall), 32'd1);
    chk({tag, ".wb_idle"}, 32'(wb_valid), 32'd0);
    next_cycle();
    data_resultRDY = stale;
    data_result    = 32'h1234_5678;
    data_exception = stale;
    #3;
    chk({tag, ".ctrl_mult"}, 32'(ctrl_MULT), 32'(mult));
    chk({tag, ".ctrl_div"}, 32'(ctrl_DIV), 32'(!mult));
    chk({tag, ".md_a"}, md_a, a);
    chk({tag, ".md_b"}, md_b, b);
    chk({tag, ".stall_start"}, 32'(stall), 32'd1);
    next_cycle();
    for (int k = 1; k <= n; k++) begin
      data_resultRDY = give_rdy && (k == n);
      data_result    = data_resultRDY ? res : 32'hDEAD_BEEF;
      data_exception = data_resultRDY ? exc : 1'b1;
      #3;
      if (ctrl_MULT || ctrl_DIV || !stall || wb_valid) bad++;
      next_cycle();
    end
    chk({tag, ".busy_cycles_bad"}, 32'(bad), 32'd0);
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    #3;
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(exp_rd));
    chk({tag, ".wb_data"}, wb_data, exp_data);
    chk({tag, ".wb_exc"}, 32'(wb_exception), 32'(exp_exc));
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    next_cycle();
    chk({tag, ".wb_count"}, 32'(wb_seen - wb0), 32'd1);
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0; op_is_mult = 1'b0; op_is_div = 1'b0;
    data_resultRDY = 1'b0; data_exception = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb0;
    reset = 1'b0;
    op_valid = 1'b0; op_is_mult = 1'b0; op_is_div = 1'b0;
    op_a = '0; op_b = '0; op_rd = '0;
    data_result = '0; data_resultRDY = 1'b0; data_exception = 1'b0;
    next_cycle();
    next_cycle();
    chk("rst.md_a", md_a, 32'd0);
    chk("rst.md_b", md_b, 32'd0);
    chk("rst.ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    chk("rst.wb", {wb_valid, wb_exception, wb_rd, wb_data[24:0]}, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    reset = 1'b1;
    idle(2);

    // 7 * -3, RDY at T+17 -> writeback at T+18
    run_op("mul7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd5, 16, 1'b1, 32'hFFFF_FFEB, 1'b0,
           1'b0, 5'd5, 32'hFFFF_FFEB, 1'b0);
    idle(1);
    chk("md_hold_a", md_a, 32'd7);
    chk("md_hold_b", md_b, 32'hFFFF_FFFD);
    run_op("mul_ovf", 1'b1, 32'h4000_0000, 32'd4, 5'd7, 4, 1'b1, 32'h0, 1'b1,
           1'b0, 5'd30, 32'd4, 1'b1);
    idle(1);
    run_op("div100_7", 1'b0, 32'd100, 32'd7, 5'd9, 6, 1'b1, 32'd14, 1'b0,
           1'b0, 5'd9, 32'd14, 1'b0);
    // Back-to-back: next op presented the cycle after DONE
    run_op("div5_0", 1'b0, 32'd5, 32'd0, 5'd11, 2, 1'b1, 32'hFFFF_FFFF, 1'b1,
           1'b0, 5'd30, 32'd5, 1'b1);
    run_op("stale_rdy", 1'b0, 32'd50, 32'd5, 5'd3, 3, 1'b1, 32'd10, 1'b0,
           1'b1, 5'd3, 32'd10, 1'b0);
    idle(1);
    run_op("timeout_mul", 1'b1, 32'd3, 32'd3, 5'd4, 40, 1'b0, 32'd0, 1'b0,
           1'b0, 5'd30, 32'd4, 1'b1);
    idle(1);
    run_op("timeout_div", 1'b0, 32'd3, 32'd3, 5'd4, 40, 1'b0, 32'd0, 1'b0,
           1'b0, 5'd30, 32'd5, 1'b1);
    idle(1);

    // Malformed type bits: ignored
    op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b1; op_a = 32'hAAAA_0001;
    #3;
    chk("both.stall", 32'(stall), 32'd0);
    next_cycle();
    op_is_mult = 1'b0; op_is_div = 1'b0;
    #3;
    chk("both.ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    chk("neither.stall", 32'(stall), 32'd0);
    next_cycle();
    #3;
    chk("neither.ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    chk("ignored.md_a", md_a, 32'd3);
    idle(1);

    // Reset mid-BUSY abandons the op
    wb0 = wb_seen;
    op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b0; op_a = 32'h55; op_b = 32'h66;
    op_rd = 5'd8;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 5; i++) next_cycle();
    op_valid = 1'b0; op_is_mult = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid.md_a", md_a, 32'd0);
    chk("rstmid.stall", 32'(stall), 32'd0);
    chk("rstmid.wb", {wb_valid, wb_exception, wb_rd, wb_data[24:0]}, 32'd0);
    next_cycle();
    reset = 1'b1;
    idle(45);
    chk("rstmid.no_wb", 32'(wb_seen - wb0), 32'd0);
    chk("rstmid.idle_stall", 32'(stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
